// File: rtl/posit_mul_sched_if.sv
// Handshake bundle for posit_mul_sched: two operand requesters, the multiplier core and the result
// consumer. slave is the scheduler's view, master is the mirrored view seen by its surroundings.
interface posit_mul_sched_if #(
  parameter int unsigned N = 16
) ();
  logic         req0_valid;
  logic         req0_ready;
  logic [N-1:0] req0_a;
  logic [N-1:0] req0_b;
  logic         req1_valid;
  logic         req1_ready;
  logic [N-1:0] req1_a;
  logic [N-1:0] req1_b;
  logic         mul_start;
  logic [N-1:0] mul_a;
  logic [N-1:0] mul_b;
  logic         mul_done;
  logic [N-1:0] mul_p;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;
  logic         res_src;
  logic         busy;
  logic         timeout_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, mul_done, mul_p, res_ready,
    output req0_ready, req1_ready, mul_start, mul_a, mul_b, res_valid, res_data, res_src, busy,
           timeout_err
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, mul_done, mul_p, res_ready,
    input  req0_ready, req1_ready, mul_start, mul_a, mul_b, res_valid, res_data, res_src, busy,
           timeout_err
  );
endinterface

// File: rtl/posit_mul_sched.sv
// Round-robin scheduler sharing one multi-cycle posit multiplier between two requesters, with a
// hung-core timeout. Define POSIT_SPECIAL_BYPASS_EN to resolve 0/NaR operands without the core.
module posit_mul_sched #(
  parameter int unsigned N           = 16,
  parameter int unsigned MUL_TIMEOUT = 64
) (
  input logic              clk,
  input logic              rst,
  posit_mul_sched_if.slave bus
);
  localparam int unsigned CntW = $clog2(MUL_TIMEOUT);
  localparam logic [N-1:0] NaR = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

  state_e         state_q, state_d;
  logic           last_grant_q;
  logic [N-1:0]   mul_a_q, mul_b_q, res_data_q;
  logic           res_valid_q, res_src_q, timeout_err_q;
  logic [CntW-1:0] cnt_q;

  logic           grant, accept, timeout_hit;
  logic [N-1:0]   sel_a, sel_b;

  // A tie goes to whoever was not granted last, so continuous contention alternates.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant_q;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  assign accept      = (state_q == StIdle) && (bus.req0_valid || bus.req1_valid);
  assign sel_a       = grant ? bus.req1_a : bus.req0_a;
  assign sel_b       = grant ? bus.req1_b : bus.req0_b;
  assign timeout_hit = (cnt_q == CntW'(MUL_TIMEOUT - 1));

`ifdef POSIT_SPECIAL_BYPASS_EN
  logic         any_nar, any_zero, bypass;
  logic [N-1:0] bypass_data;

  assign any_nar     = (sel_a == NaR) || (sel_b == NaR);
  assign any_zero    = (sel_a == '0) || (sel_b == '0);
  assign bypass      = any_nar || any_zero;
  assign bypass_data = any_nar ? NaR : '0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
`ifdef POSIT_SPECIAL_BYPASS_EN
          state_d = bypass ? StHold : StIssue;
`else
          state_d = StIssue;
`endif
        end
      end
      StIssue: state_d = StWait;
      StWait:  if (bus.mul_done || timeout_hit) state_d = StHold;
      StHold:  if (bus.res_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      last_grant_q  <= 1'b1;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      res_data_q    <= '0;
      res_valid_q   <= 1'b0;
      res_src_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (accept) begin
            mul_a_q      <= sel_a;
            mul_b_q      <= sel_b;
            res_src_q    <= grant;
            last_grant_q <= grant;
`ifdef POSIT_SPECIAL_BYPASS_EN
            if (bypass) begin
              res_data_q  <= bypass_data;
              res_valid_q <= 1'b1;
            end
`endif
          end
        end
        StIssue: cnt_q <= '0;
        StWait: begin
          cnt_q <= cnt_q + CntW'(1);
          // done takes priority over a coincident timeout
          if (bus.mul_done) begin
            res_data_q  <= bus.mul_p;
            res_valid_q <= 1'b1;
          end else if (timeout_hit) begin
            res_data_q    <= NaR;
            res_valid_q   <= 1'b1;
            timeout_err_q <= 1'b1;
          end
        end
        StHold: if (bus.res_ready) res_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.req0_ready  = accept && !grant;
  assign bus.req1_ready  = accept && grant;
  assign bus.mul_start   = (state_q == StIssue);
  assign bus.mul_a       = mul_a_q;
  assign bus.mul_b       = mul_b_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_src     = res_src_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_posit_mul_sched.sv
// Bench for posit_mul_sched: directed scenarios plus randomized traffic scored against a
// transaction-level arbitration/result model and a behavioural multiplier core.
module tb_posit_mul_sched;
  localparam int unsigned N   = 16;
  localparam int unsigned MT  = 12;
  localparam logic [15:0] NAR = 16'h8000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  posit_mul_sched_if #(.N(N)) bus ();
  posit_mul_sched #(.N(N), .MUL_TIMEOUT(MT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // behavioural core
  int          core_lat = 1;
  bit          core_rand = 1'b0;
  bit          core_force = 1'b0;
  logic [15:0] core_force_val = '0;
  bit          core_pend = 1'b0;
  int          core_t = 0;
  int          core_due = 0;
  logic [15:0] core_a, core_b;
  int          starts = 0;

  // scoreboard / requester queues
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [16:0] sb[$];
  bit          glog[$];
  bit          last_m = 1'b1;

  function automatic logic [15:0] core_fn(logic [15:0] a, logic [15:0] b);
    logic [31:0] p;
    p = a * b;
    return p[15:0] ^ 16'h00a5;
  endfunction

  function automatic logic [15:0] ref_mul(logic [15:0] a, logic [15:0] b);
`ifdef POSIT_SPECIAL_BYPASS_EN
    if (a == NAR || b == NAR) return NAR;
    if (a == 16'h0 || b == 16'h0) return 16'h0;
`endif
    return core_fn(a, b);
  endfunction

  function automatic logic [15:0] rand_op(bit allow_special);
    logic [15:0] x;
    x = 16'($urandom);
    if (allow_special && $urandom_range(0, 7) == 0) x = ($urandom_range(0, 1) == 1) ? NAR : 16'h0;
    else if (x == 16'h0 || x == NAR) x = 16'h1234;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    bus.mul_done = 1'b0;
    bus.mul_p    = '0;
    if (bus.mul_start) begin
      starts++;
      core_pend = 1'b1;
      core_t    = cyc;
      core_a    = bus.mul_a;
      core_b    = bus.mul_b;
      core_due  = core_rand ? cyc + int'($urandom_range(1, 6)) : cyc + core_lat;
    end
    if (core_pend && (core_rand || core_lat >= 0) && cyc == core_due) begin
      bus.mul_done = 1'b1;
      bus.mul_p    = core_force ? core_force_val : core_fn(core_a, core_b);
      core_pend    = 1'b0;
    end
    #1;
    vectors++;
    if (bus.req0_ready && bus.req1_ready) begin
      miscompares++;
      $display("FAIL two_readies cyc=%0d: got both ready, required at most one", cyc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.res_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    core_pend = 1'b0;
    last_m = 1'b1;
  endtask

  // Drives one pair from src, consumes the result immediately; latency is res_valid - accept.
  task automatic one_op(input bit src, input logic [15:0] a, input logic [15:0] b, output bit ok,
                        output int acc, output int lat, output logic [15:0] data, output bit s);
    ok = 1'b0; acc = -1; lat = -1; data = '0; s = 1'b0;
    bus.res_ready = 1'b1;
    if (src) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
    end
    #1;
    for (int i = 0; i < 20; i++) begin
      if (src ? bus.req1_ready : bus.req0_ready) begin
        acc = cyc;
        break;
      end
      tick();
    end
    if (acc < 0) begin
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      return;
    end
    last_m = src;
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    for (int i = 0; i < int'(MT) + 40; i++) begin
      if (bus.res_valid) begin
        lat = cyc - acc; data = bus.res_data; s = bus.res_src; ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
  endtask

  // Runs queued traffic; the model predicts readies from "one op in flight" + round-robin rule.
  task automatic run_engine(input int rdy_pct, input int budget);
    bit outst, v0, v1, e0, e1;
    logic [31:0] pr;
    logic [16:0] ex;
    int c;
    outst = 1'b0;
    c = 0;
    while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0 || outst) && c < budget) begin
      bus.res_ready  = ($urandom_range(0, 99) < rdy_pct);
      v0 = (q0.size() > 0);
      v1 = (q1.size() > 0);
      bus.req0_valid = v0;
      bus.req1_valid = v1;
      if (v0) {bus.req0_a, bus.req0_b} = q0[0];
      if (v1) {bus.req1_a, bus.req1_b} = q1[0];
      #1;
      e0 = !outst && v0 && (!v1 || last_m);
      e1 = !outst && v1 && (!v0 || !last_m);
      vectors++;
      if ({bus.req0_ready, bus.req1_ready} !== {e0, e1}) begin
        miscompares++;
        $display("FAIL grant cyc=%0d: got ready=%b%b, required %b%b", cyc, bus.req0_ready,
                 bus.req1_ready, e0, e1);
      end
      vectors++;
      if (bus.busy !== outst) begin
        miscompares++;
        $display("FAIL busy cyc=%0d: got %b, required %b", cyc, bus.busy, outst);
      end
      if (bus.req0_ready) glog.push_back(1'b0);
      if (bus.req1_ready) glog.push_back(1'b1);
      if (bus.res_valid && bus.res_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL spurious_result cyc=%0d: got data=%h, required no result", cyc,
                   bus.res_data);
        end else begin
          ex = sb.pop_front();
          if ({bus.res_src, bus.res_data} !== ex) begin
            miscompares++;
            $display("FAIL result cyc=%0d: got src=%b data=%h, required src=%b data=%h", cyc,
                     bus.res_src, bus.res_data, ex[16], ex[15:0]);
          end
        end
        outst = 1'b0;
      end
      if (e0) begin
        pr = q0.pop_front();
        sb.push_back({1'b0, ref_mul(pr[31:16], pr[15:0])});
        last_m = 1'b0; outst = 1'b1;
      end else if (e1) begin
        pr = q1.pop_front();
        sb.push_back({1'b1, ref_mul(pr[31:16], pr[15:0])});
        last_m = 1'b1; outst = 1'b1;
      end
      tick();
      c++;
    end
    vectors++;
    if (c >= budget) begin
      miscompares++;
      $display("FAIL engine_budget: got %0d cycles with work pending, required < %0d", c, budget);
      q0.delete(); q1.delete(); sb.delete();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.res_ready  = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] obs[10];
    string       nm[10];
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.res_ready = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.mul_done = 1'b0; bus.mul_p = '0;
    tick(); tick(); tick();
    obs = '{16'(bus.req0_ready), 16'(bus.req1_ready), 16'(bus.mul_start), bus.mul_a, bus.mul_b,
            16'(bus.res_valid), bus.res_data, 16'(bus.res_src), 16'(bus.busy),
            16'(bus.timeout_err)};
    nm  = '{"req0_ready", "req1_ready", "mul_start", "mul_a", "mul_b", "res_valid", "res_data",
            "res_src", "busy", "timeout_err"};
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (obs[i] !== 16'h0) begin
        miscompares++;
        $display("FAIL reset_%s: got %h, required 0", nm[i], obs[i]);
      end
    end
    rst = 1'b0;
    last_m = 1'b1;
  endtask

  task automatic test_single();
    bit ok, s;
    int acc, lat, s0;
    logic [15:0] d;
    do_reset();
    core_rand = 1'b0; core_lat = 3; core_force = 1'b1; core_force_val = 16'h4000;
    s0 = starts;
    one_op(1'b0, 16'h4000, 16'h4000, ok, acc, lat, d, s);
    core_force = 1'b0;
    vectors++;
    if (!ok || lat != 5) begin
      miscompares++; $display("FAIL single_latency: got ok=%b lat=%0d, required lat 5", ok, lat);
    end
    vectors++;
    if (core_t - acc != 1 || starts - s0 != 1) begin
      miscompares++;
      $display("FAIL single_start: got start at +%0d count %0d, required +1 count 1",
               core_t - acc, starts - s0);
    end
    vectors++;
    if (d !== 16'h4000 || s !== 1'b0) begin
      miscompares++;
      $display("FAIL single_result: got data=%h src=%b, required 4000 src 0", d, s);
    end
  endtask

  task automatic test_alternate();
    do_reset();
    core_rand = 1'b0; core_lat = 1;
    glog.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back({rand_op(1'b0), rand_op(1'b0)});
      q1.push_back({rand_op(1'b0), rand_op(1'b0)});
    end
    run_engine(100, 200);
    vectors++;
    if (glog.size() != 8) begin
      miscompares++; $display("FAIL alt_count: got %0d grants, required 8", glog.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (glog[i] !== 1'(i % 2)) begin
          miscompares++;
          $display("FAIL alt_order[%0d]: got %b, required %b", i, glog[i], 1'(i % 2));
        end
      end
    end
  endtask

  task automatic test_timeout();
    bit ok, s;
    int acc, lat;
    logic [15:0] d, a, b;
    do_reset();
    core_rand = 1'b0; core_lat = -1;
    one_op(1'b1, rand_op(1'b0), rand_op(1'b0), ok, acc, lat, d, s);
    vectors++;
    if (!ok || lat != int'(MT) + 2 || d !== NAR || s !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_result: got ok=%b lat=%0d data=%h src=%b, required lat %0d 8000 1",
               ok, lat, d, s, MT + 2);
    end
    vectors++;
    if (bus.timeout_err !== 1'b1) begin
      miscompares++; $display("FAIL timeout_err_set: got %b, required 1", bus.timeout_err);
    end
    core_rand = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q0.push_back({rand_op(1'b0), rand_op(1'b0)});
      q1.push_back({rand_op(1'b0), rand_op(1'b0)});
    end
    run_engine(70, 400);
    vectors++;
    if (bus.timeout_err !== 1'b1) begin
      miscompares++; $display("FAIL timeout_err_sticky: got %b, required 1", bus.timeout_err);
    end
    // done in the very cycle the counter expires must win
    do_reset();
    core_rand = 1'b0; core_lat = MT;
    a = rand_op(1'b0); b = rand_op(1'b0);
    one_op(1'b0, a, b, ok, acc, lat, d, s);
    vectors++;
    if (!ok || lat != int'(MT) + 2 || d !== ref_mul(a, b) || bus.timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL done_vs_timeout: got lat=%0d data=%h err=%b, required lat %0d %h 0", lat,
               d, bus.timeout_err, MT + 2, ref_mul(a, b));
    end
  endtask

  task automatic test_hold();
    logic [15:0] a, b, d0;
    bit got;
    do_reset();
    core_rand = 1'b0; core_lat = 1;
    bus.res_ready = 1'b0;
    a = rand_op(1'b0); b = rand_op(1'b0);
    bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
    #1;
    vectors++;
    if (bus.req0_ready !== 1'b1) begin
      miscompares++; $display("FAIL hold_accept: got %b, required 1", bus.req0_ready);
    end
    tick();
    bus.req0_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (bus.res_valid) got = 1'b1;
      else tick();
    end
    d0 = bus.res_data;
    vectors++;
    if (!got || d0 !== ref_mul(a, b)) begin
      miscompares++;
      $display("FAIL hold_first: got valid=%b data=%h, required %h", got, d0, ref_mul(a, b));
    end
    bus.req0_valid = 1'b1; bus.req0_a = rand_op(1'b0); bus.req0_b = rand_op(1'b0);
    bus.req1_valid = 1'b1; bus.req1_a = rand_op(1'b0); bus.req1_b = rand_op(1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      bus.mul_done = 1'b1; bus.mul_p = 16'hdead;
      #1;
      vectors++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== d0 || bus.res_src !== 1'b0 ||
          bus.req0_ready || bus.req1_ready || bus.mul_start) begin
        miscompares++;
        $display("FAIL hold_stable[%0d]: got v=%b d=%h s=%b rdy=%b%b st=%b, required 1 %h 0 00 0",
                 i, bus.res_valid, bus.res_data, bus.res_src, bus.req0_ready, bus.req1_ready,
                 bus.mul_start, d0);
      end
    end
    bus.res_ready = 1'b1;
    #1;
    vectors++;
    if (bus.req0_ready || bus.req1_ready) begin
      miscompares++; $display("FAIL hold_hs_ready: got %b%b, required 00", bus.req0_ready,
                              bus.req1_ready);
    end
    tick();
    bus.mul_done = 1'b1; bus.mul_p = 16'hdead;
    #1;
    vectors++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req1_ready !== 1'b1 ||
        bus.req0_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_release: got v=%b busy=%b rdy=%b%b, required 0 0 01", bus.res_valid,
               bus.busy, bus.req0_ready, bus.req1_ready);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    tick();
    vectors++;
    if (bus.res_data !== d0 || bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_done_ignored: got d=%h v=%b busy=%b, required %h 0 0", bus.res_data,
               bus.res_valid, bus.busy, d0);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    core_rand = 1'b0; core_lat = -1;
    bus.res_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = rand_op(1'b0); bus.req0_b = rand_op(1'b0);
    #1;
    tick();
    bus.req0_valid = 1'b0;
    tick(); tick();
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++; $display("FAIL rst_mid_busy: got %b, required 1", bus.busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    core_pend = 1'b0;
    last_m = 1'b1;
    bus.mul_done = 1'b1; bus.mul_p = 16'h1234;
    #1;
    vectors++;
    if (bus.busy || bus.res_valid || bus.mul_start || bus.mul_a !== 16'h0 ||
        bus.res_data !== 16'h0 || bus.timeout_err) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got busy=%b v=%b st=%b a=%h d=%h err=%b, required all 0",
               bus.busy, bus.res_valid, bus.mul_start, bus.mul_a, bus.res_data, bus.timeout_err);
    end
    tick();
    vectors++;
    if (bus.res_valid || bus.res_data !== 16'h0 || bus.busy) begin
      miscompares++;
      $display("FAIL rst_late_done: got v=%b d=%h busy=%b, required 0 0000 0", bus.res_valid,
               bus.res_data, bus.busy);
    end
    core_lat = 2;
    q0.push_back({rand_op(1'b0), rand_op(1'b0)});
    q1.push_back({rand_op(1'b0), rand_op(1'b0)});
    run_engine(100, 100);
  endtask

  task automatic test_special();
    bit ok, s;
    int acc, lat, s0, exp_lat, exp_st;
    logic [15:0] d;
`ifdef POSIT_SPECIAL_BYPASS_EN
    exp_lat = 1; exp_st = 0;
`else
    exp_lat = 4; exp_st = 1;
`endif
    do_reset();
    core_rand = 1'b0; core_lat = 2;
    s0 = starts;
    one_op(1'b0, 16'h0000, 16'h5A00, ok, acc, lat, d, s);
    vectors++;
    if (!ok || lat != exp_lat || starts - s0 != exp_st || d !== ref_mul(16'h0000, 16'h5A00)) begin
      miscompares++;
      $display("FAIL special_zero: got lat=%0d starts=%0d data=%h, required %0d %0d %h", lat,
               starts - s0, d, exp_lat, exp_st, ref_mul(16'h0000, 16'h5A00));
    end
    s0 = starts;
    one_op(1'b1, NAR, 16'h0000, ok, acc, lat, d, s);
    vectors++;
    if (!ok || lat != exp_lat || starts - s0 != exp_st || d !== ref_mul(NAR, 16'h0000) ||
        s !== 1'b1) begin
      miscompares++;
      $display("FAIL special_nar: got lat=%0d starts=%0d data=%h src=%b, required %0d %0d %h 1",
               lat, starts - s0, d, s, exp_lat, exp_st, ref_mul(NAR, 16'h0000));
    end
  endtask

  task automatic test_random();
    do_reset();
    core_rand = 1'b1;
    for (int i = 0; i < int'($urandom_range(5, 12)); i++)
      q0.push_back({rand_op(1'b1), rand_op(1'b1)});
    for (int i = 0; i < int'($urandom_range(5, 12)); i++)
      q1.push_back({rand_op(1'b1), rand_op(1'b1)});
    run_engine(60, 2000);
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_timeout();
    test_hold();
    test_rst_mid();
    test_special();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by cycle %0d, required finish", cyc);
    $fatal(1);
  end
endmodule
